rr_mux_sel_ctrl: RTL and testbench
==================================

Name: rr_mux_sel_ctrl

Overview:
- Round-robin select controller that sits directly upstream of the 4:1 data selector and drives its sel1/sel0 inputs.
- Four sources raise requests. The block grants one at a time for a bounded dwell period, then rotates fairly to the next requester.
- Provides registered select bits, a one-hot grant, and a valid flag telling the consumer that the selector output is meaningful.

Parameters:
- DWELL, 4, maximum cycles a granted channel holds the selector (legal range 1..255).
- CNT_W, 8, dwell counter width; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  per-channel request, bit i = channel i (channel 0 ↔ selector input a, 1 ↔ b, 2 ↔ c, 3 ↔ d)
- sel0  output  1  low select bit to the 4:1 selector
- sel1  output  1  high select bit to the 4:1 selector
- grant  output  4  one-hot grant, zero when idle
- valid  output  1  high while a channel is granted
- switch_p  output  1  one-cycle pulse on every new grant, including the first grant after IDLE

Behaviour:
- All outputs are registered.
- Reset, sampled at a clk edge with rst=1, sets:
  - sel1=0, sel0=0, grant=0, valid=0, switch_p=0
  - state=IDLE, ptr=0, cnt=0
- rst has priority over every other event, including mid-grant; the grant drops on the cycle after reset is sampled.
- ptr is the 2-bit search start: the channel after the last granted one, wrapping 3→0.
- Pick function: the first set bit of req, scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
- FSM state IDLE:
  - valid=0, grant=0; sel1/sel0 hold their last value and are not cleared.
  - If req≠0, pick channel k. Next cycle: state=ACTIVE, grant=1<<k, {sel1,sel0}=k, valid=1, switch_p=1, cnt=DWELL-1.
  - Latency is one cycle from req sampled to grant visible.
- FSM state ACTIVE, with g as the current channel:
  - Release condition: cnt==0 OR req[g]==0.
  - No release: cnt decrements, all outputs hold, switch_p=0.
  - On release: ptr=(g+1) mod 4, then pick again with the new ptr, excluding g for this decision only.
  - Another requester found: switch directly with no idle bubble (grant, sel and cnt reload, switch_p=1, valid stays 1).
  - No other requester found: go to IDLE (valid=0, grant=0).
  - A sole requester with req[g] still high after its dwell expires is regranted after exactly one IDLE cycle. This guarantees a visible rotation boundary.
- DWELL=1: every grant lasts exactly one cycle. Under saturated requests the select bits change every cycle.
- Simultaneous events:
  - A request rising on channel g at the same edge it is released has no effect.
  - A request withdrawn before the grant appears: the grant still appears for one cycle, then releases via req[g]==0.
- Invariants the checker holds:
  - grant is one-hot or zero.
  - valid == |grant.
  - {sel1,sel0} equals the index of grant whenever valid=1.
- Arithmetic: cnt is unsigned CNT_W bits and never underflows, because reload happens before 0 is passed. ptr wraps modulo 4.

Decomposition:
- Package rr_sel_pkg:
  - NCH=4, SEL_W=2
  - state typedef {IDLE, ACTIVE}
  - function idx_to_onehot
- Sub-module rr_pick (combinational): inputs req[3:0], ptr[1:0], excl_en, excl_idx[1:0]; outputs found, idx[1:0]. It is instantiated once.
- The FSM, dwell counter and output registers live in the top module.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles with req=4'b1111 → during reset and one cycle after, grant=0, valid=0, sel=00; the first grant appears on the second cycle after rst falls (ch0, switch_p=1).
- Saturated rotation, DWELL=4, req=1111 held → grants ch0,1,2,3,0, each exactly 4 cycles; {sel1,sel0} = 00,01,10,11,00; switch_p pulses every 4 cycles; valid continuously 1.
- Early release, DWELL=4: req=0001 for 2 cycles then 0100 → ch0 granted, drops after req[0] falls, ch2 granted on the following cycle with no gap, sel=10.
- Sole requester, DWELL=3: req=0010 held → ch1 valid for 3 cycles, 1 IDLE cycle (valid=0, sel holds 01), then regranted; the pattern repeats with a period of 4 cycles.
- Mid-grant reset: during a ch3 grant with cnt=2, pulse rst for 1 cycle → the next cycle shows valid=0, grant=0, sel=00, ptr=0; with req=1000 still high, ch3 is regranted one cycle later.
- DWELL=1 with req=1010 → grant alternates ch1/ch3 every cycle; sel alternates 01/11; switch_p stays high continuously.

Source files
------------

// File: rtl/rr_mux_sel_ctrl_pkg.sv
// Shared types and helpers for the round-robin select controller.
package rr_sel_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    function automatic logic [NCH-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NCH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_mux_sel_ctrl_if.sv
// Request/select bundle between requesters, the controller and the 4:1 selector.
interface rr_mux_sel_ctrl_if;
    import rr_sel_pkg::*;

    logic [NCH-1:0] req;
    logic           sel0;
    logic           sel1;
    logic [NCH-1:0] grant;
    logic           valid;
    logic           switch_p;

    modport master (
        output req,
        input  sel0, sel1, grant, valid, switch_p
    );

    modport slave (
        input  req,
        output sel0, sel1, grant, valid, switch_p
    );

endinterface

// File: rtl/rr_mux_sel_ctrl_pick.sv
// Combinational round-robin picker: first set request scanning from ptr, optionally skipping one channel.
module rr_pick
    import rr_sel_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             excl_en,
    input  logic [SEL_W-1:0] excl_idx,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand] && !(excl_en && (cand == excl_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_sel_ctrl.sv
// Round-robin select controller driving sel1/sel0 of a 4:1 data selector with bounded dwell.
module rr_mux_sel_ctrl
    import rr_sel_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux_sel_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NCH-1:0]   grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             switch_q, switch_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] pick_ptr;
    logic             pick_excl;

    // While active the only decision is a release, which searches from g+1 and skips g.
    assign pick_excl = (state_q == ACTIVE);
    assign pick_ptr  = pick_excl ? (sel_q + 2'd1) : ptr_q;

    rr_pick u_pick (
        .req      (bus.req),
        .ptr      (pick_ptr),
        .excl_en  (pick_excl),
        .excl_idx (sel_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        switch_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (pick_found) begin
                    state_d  = ACTIVE;
                    sel_d    = pick_idx;
                    grant_d  = idx_to_onehot(pick_idx);
                    valid_d  = 1'b1;
                    switch_d = 1'b1;
                    cnt_d    = RELOAD;
                end
            end
            ACTIVE: begin
                if ((cnt_q == '0) || !bus.req[sel_q]) begin
                    ptr_d = sel_q + 2'd1;
                    if (pick_found) begin
                        sel_d    = pick_idx;
                        grant_d  = idx_to_onehot(pick_idx);
                        switch_d = 1'b1;
                        cnt_d    = RELOAD;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            switch_q <= switch_d;
        end
    end

    assign bus.sel0     = sel_q[0];
    assign bus.sel1     = sel_q[1];
    assign bus.grant    = grant_q;
    assign bus.valid    = valid_q;
    assign bus.switch_p = switch_q;

endmodule

// File: tb/tb_rr_mux_sel_ctrl.sv
// Scoreboard bench: three controller instances (DWELL 4, 3, 1) share clk/rst/req and are checked every cycle.
module tb_rr_mux_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b1111;

    always #5 clk = ~clk;

    rr_mux_sel_ctrl_if bus4 ();
    rr_mux_sel_ctrl_if bus3 ();
    rr_mux_sel_ctrl_if bus1 ();

    assign bus4.req = req;
    assign bus3.req = req;
    assign bus1.req = req;

    rr_mux_sel_ctrl #(.DWELL(4), .CNT_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    rr_mux_sel_ctrl #(.DWELL(3), .CNT_W(8)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
    rr_mux_sel_ctrl #(.DWELL(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [3:0] o_grant [3];
    logic [1:0] o_sel   [3];
    logic       o_valid [3];
    logic       o_sw    [3];

    assign o_grant[0] = bus4.grant;  assign o_sel[0] = {bus4.sel1, bus4.sel0};
    assign o_valid[0] = bus4.valid;  assign o_sw[0]  = bus4.switch_p;
    assign o_grant[1] = bus3.grant;  assign o_sel[1] = {bus3.sel1, bus3.sel0};
    assign o_valid[1] = bus3.valid;  assign o_sw[1]  = bus3.switch_p;
    assign o_grant[2] = bus1.grant;  assign o_sel[2] = {bus1.sel1, bus1.sel0};
    assign o_valid[2] = bus1.valid;  assign o_sw[2]  = bus1.switch_p;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic       sw;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one slot per instance
    int dwell [3] = '{4, 3, 1};
    bit m_act [3];
    int m_ptr [3];
    int m_cnt [3];
    int m_g   [3];
    bit m_sw  [3];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start, input int excl);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_tick(input int i);
        int c;
        m_sw[i] = 1'b0;
        if (rst) begin
            m_act[i] = 1'b0; m_ptr[i] = 0; m_cnt[i] = 0; m_g[i] = 0;
        end else if (!m_act[i]) begin
            c = pick(req, m_ptr[i], -1);
            if (c >= 0) begin
                m_act[i] = 1'b1; m_g[i] = c; m_cnt[i] = dwell[i] - 1; m_sw[i] = 1'b1;
            end
        end else if (m_cnt[i] == 0 || !req[m_g[i]]) begin
            m_ptr[i] = (m_g[i] + 1) % 4;
            c = pick(req, m_ptr[i], m_g[i]);
            if (c >= 0) begin
                m_g[i] = c; m_cnt[i] = dwell[i] - 1; m_sw[i] = 1'b1;
            end else begin
                m_act[i] = 1'b0;
            end
        end else begin
            m_cnt[i] = m_cnt[i] - 1;
        end
    endtask

    task automatic step();
        exp_t e;
        int   gi;
        for (int i = 0; i < 3; i++) begin
            model_tick(i);
            e.valid = m_act[i];
            e.grant = m_act[i] ? (4'b0001 << m_g[i]) : 4'b0000;
            e.sel   = 2'(m_g[i]);
            e.sw    = m_sw[i];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("grant[%0d]", i), 32'(o_grant[i]), 32'(e.grant));
                chk($sformatf("sel[%0d]", i),   32'(o_sel[i]),   32'(e.sel));
                chk($sformatf("valid[%0d]", i), 32'(o_valid[i]), 32'(e.valid));
                chk($sformatf("sw[%0d]", i),    32'(o_sw[i]),    32'(e.sw));
            end
            chk($sformatf("onehot[%0d]", i), 32'($countones(o_grant[i]) <= 1), 32'd1);
            chk($sformatf("vld_or[%0d]", i), 32'(o_valid[i]), 32'(|o_grant[i]));
            if (o_valid[i]) begin
                gi = 0;
                for (int b = 0; b < 4; b++) if (o_grant[i][b]) gi = b;
                chk($sformatf("sel_idx[%0d]", i), 32'(o_sel[i]), 32'(gi));
            end
        end
    endtask

    int rot_sel [4] = '{1, 2, 3, 0};
    bit sole_pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    logic [1:0] prev_sel;

    initial begin
        // Reset with all channels requesting, then saturated rotation
        rst = 1'b1; req = 4'b1111;
        step(); step();
        chk("rst_grant", 32'(o_grant[0]), 32'h0);
        chk("rst_sel",   32'(o_sel[0]),   32'h0);
        rst = 1'b0;
        step();
        chk("first_grant", 32'(o_grant[0]), 32'h1);
        chk("first_sw",    32'(o_sw[0]),    32'h1);
        for (int t = 1; t <= 16; t++) begin
            step();
            chk("rot_valid", 32'(o_valid[0]), 32'h1);
            chk("rot_sw", 32'(o_sw[0]), 32'((t % 4) == 0));
            if ((t % 4) == 0) chk("rot_sel", 32'(o_sel[0]), 32'(rot_sel[t/4 - 1]));
        end

        // Early release: ch0 drops its request, ch2 taken with no gap
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b0001;
        step(); step();
        req = 4'b0100;
        step();
        chk("early_grant", 32'(o_grant[0]), 32'h4);
        chk("early_sel",   32'(o_sel[0]),   32'h2);
        chk("early_sw",    32'(o_sw[0]),    32'h1);
        step(); step();

        // Sole requester on the DWELL=3 instance
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b0010;
        for (int t = 0; t < 8; t++) begin
            step();
            chk("sole_valid", 32'(o_valid[1]), 32'(sole_pat[t]));
            chk("sole_sel",   32'(o_sel[1]),   32'h1);
        end

        // Reset in the middle of a ch3 grant
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b1000;
        step(); step();
        rst = 1'b1; step();
        chk("midrst_valid", 32'(o_valid[0]), 32'h0);
        chk("midrst_sel",   32'(o_sel[0]),   32'h0);
        rst = 1'b0; step();
        chk("midrst_regrant", 32'(o_grant[0]), 32'h8);

        // DWELL=1 alternating between ch1 and ch3
        req = 4'b1010;
        step(); step();
        prev_sel = o_sel[2];
        for (int t = 0; t < 8; t++) begin
            step();
            chk("d1_sw",   32'(o_sw[2]), 32'h1);
            chk("d1_alt",  32'(o_sel[2]), 32'(prev_sel ^ 2'b10));
            prev_sel = o_sel[2];
        end

        // Random traffic with occasional reset
        for (int t = 0; t < 300; t++) begin
            req = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
